// File: rtl/digit_scan_controller.sv
// rtl/digit_scan_controller.sv - digit scan source for a 2-to-4 display decoder
//
// Purpose:
//   Steps a 2-bit digit index 0,1,2,3 at a rate of one digit per PRESCALE
//   enabled clock cycles. The index drives the decoder select lines a/b, and
//   the matching nibble of the displayed word is presented alongside it.
//   New display words are double-buffered. A word loaded mid-frame waits in
//   a shadow register and is promoted to the active word at the frame wrap,
//   so a single frame never mixes old and new digits.
//
// Parameters:
//   PRESCALE     enabled cycles spent on each digit (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           scan enable; when low the scan freezes and digits are unlit
//   load         one-cycle strobe capturing load_data
//   load_data    16-bit display word, nibble k = load_data[4k+3:4k]
//   blank_mask   per-digit blank, bit k unlights digit k
//   a            index MSB (decoder a)
//   b            index LSB (decoder b)
//   nibble       active-word nibble for the current index
//   digit_valid  current digit should be lit
//   frame_done   one-cycle pulse on the first cycle of each new frame

module digit_scan_controller #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic [3:0]  blank_mask,
  output logic        a,
  output logic        b,
  output logic [3:0]  nibble,
  output logic        digit_valid,
  output logic        frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic          pending;

  logic          step;
  logic          wrap;

  // A step ends the last enabled cycle of a digit; the step out of digit 3
  // closes the frame.
  assign step = en && (pcnt == PCNT_MAX);
  assign wrap = step && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= 2'd0;
      active     <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        if (pcnt == PCNT_MAX) begin
          pcnt <= '0;
          idx  <= idx + 2'd1;
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end

      frame_done <= wrap;

      if (wrap) begin
        // A load coinciding with the wrap bypasses the shadow so it is
        // visible on the very next cycle; the shadow is then stale and
        // must not be promoted again.
        if (load) begin
          active  <= load_data;
          pending <= 1'b0;
        end else if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (load) begin
        shadow  <= load_data;
        pending <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only; en and blank_mask are the only
  // inputs with a combinational path, and only into digit_valid.
  assign a           = idx[1];
  assign b           = idx[0];
  assign nibble      = active[{idx, 2'b00} +: 4];
  assign digit_valid = en & ~blank_mask[idx];

endmodule

// File: tb/tb_digit_scan_controller.sv
// tb/tb_digit_scan_controller.sv - self-checking bench for digit_scan_controller

module tb_digit_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        en, load;
  logic [15:0] load_data;
  logic [3:0]  blank_mask;
  logic        a, b, digit_valid, frame_done;
  logic [3:0]  nibble;

  logic        en1, load1;
  logic [15:0] load_data1;
  logic [3:0]  blank_mask1;
  logic        a1, b1, digit_valid1, frame_done1;
  logic [3:0]  nibble1;

  always #5 clk = ~clk;

  digit_scan_controller #(.PRESCALE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_data(load_data),
    .blank_mask(blank_mask), .a(a), .b(b), .nibble(nibble),
    .digit_valid(digit_valid), .frame_done(frame_done)
  );

  digit_scan_controller #(.PRESCALE(1)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .load(load1), .load_data(load_data1),
    .blank_mask(blank_mask1), .a(a1), .b(b1), .nibble(nibble1),
    .digit_valid(digit_valid1), .frame_done(frame_done1)
  );

  typedef struct {
    string      tag;
    logic [7:0] v;   // {a, b, nibble, digit_valid, frame_done}
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference position: enabled cycles since reset. The expected index and
  // frame boundaries follow from it directly.
  int          k;
  int          k1;
  logic [15:0] disp;
  logic [15:0] next_word;
  logic        have_next;

  function automatic logic [7:0] obs4();
    return {a, b, nibble, digit_valid, frame_done};
  endfunction

  function automatic logic [7:0] obs1();
    return {a1, b1, nibble1, digit_valid1, frame_done1};
  endfunction

  task automatic push(input string tag, input logic [1:0] ab, input logic [3:0] nib,
                      input logic dv, input logic fd);
    exp_t e;
    e.tag = tag;
    e.v   = {ab, nib, dv, fd};
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h ({a,b,nibble,dv,fd})", e.tag, obs, e.v);
    end
  endtask

  task automatic tick4(input string tag);
    int   ix;
    logic fd;
    fd = 1'b0;
    if (en) begin
      k++;
      fd = (k % 16 == 0);
    end
    if (fd) begin
      if (load) begin
        disp      = load_data;
        have_next = 1'b0;
      end else if (have_next) begin
        disp      = next_word;
        have_next = 1'b0;
      end
    end else if (load) begin
      next_word = load_data;
      have_next = 1'b1;
    end
    ix = (k / 4) % 4;
    push($sformatf("%s_k%0d", tag, k), 2'(ix), disp[4*ix +: 4], en & ~blank_mask[ix], fd);
    @(posedge clk);
    #1;
    check(obs4());
  endtask

  task automatic tick1(input string tag);
    int   ix;
    logic fd;
    fd = 1'b0;
    if (en1) begin
      k1++;
      fd = (k1 % 4 == 0);
    end
    ix = k1 % 4;
    push($sformatf("%s_k%0d", tag, k1), 2'(ix), 4'h0, en1 & ~blank_mask1[ix], fd);
    @(posedge clk);
    #1;
    check(obs1());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_data = 16'h0; blank_mask = 4'b0000;
    en1 = 1'b0; load1 = 1'b0; load_data1 = 16'h0; blank_mask1 = 4'b0101;
    k = 0; k1 = 0; disp = 16'h0; next_word = 16'h0; have_next = 1'b0;

    #1;
    push("reset_en0", 2'd0, 4'h0, 1'b0, 1'b0); check(obs4());
    push("p1_reset", 2'd0, 4'h0, 1'b0, 1'b0);  check(obs1());
    en = 1'b1;
    #1;
    push("reset_en1", 2'd0, 4'h0, 1'b1, 1'b0); check(obs4());

    // Release reset and load 4321; it becomes active at the first wrap.
    @(negedge clk);
    rst_n = 1'b1;
    load = 1'b1; load_data = 16'h4321;
    tick4("load4321");
    load = 1'b0;
    repeat (31) tick4("scan");

    // Load ABCD while idx=1: digits 2,3 keep old data until the wrap.
    repeat (4) tick4("to_idx1");
    load = 1'b1; load_data = 16'hABCD;
    tick4("load_abcd");
    load = 1'b0;
    repeat (15) tick4("dbuf");

    // Two loads in one frame: the last one wins.
    load = 1'b1; load_data = 16'h1111;
    tick4("load_1111");
    load = 1'b0;
    repeat (2) tick4("gap");
    load = 1'b1; load_data = 16'h2222;
    tick4("load_2222");
    load = 1'b0;
    repeat (23) tick4("last_wins");

    // Load on the wrap cycle bypasses the shadow; the next wrap keeps 00F0.
    load = 1'b1; load_data = 16'h00F0;
    tick4("wrap_load");
    load = 1'b0;
    repeat (16) tick4("bypass");

    // Freeze at idx=2, pcnt=3 with a load accepted while frozen.
    repeat (11) tick4("to_freeze");
    en = 1'b0;
    repeat (3) tick4("freeze");
    load = 1'b1; load_data = 16'h5678;
    tick4("freeze_load");
    load = 1'b0;
    repeat (6) tick4("freeze");
    en = 1'b1;
    tick4("resume");
    repeat (5) tick4("post_freeze");

    // Leave a load pending, then reset asynchronously mid-scan.
    load = 1'b1; load_data = 16'h9999;
    tick4("pend_9999");
    load = 1'b0;
    repeat (3) tick4("pre_reset");
    #3;
    rst_n = 1'b0;
    k = 0; disp = 16'h0; have_next = 1'b0; k1 = 0;
    #1;
    push("async_reset", 2'd0, 4'h0, 1'b1, 1'b0); check(obs4());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick4("after_reset");

    // PRESCALE=1 instance with digits 0 and 2 blanked.
    en1 = 1'b1;
    #1;
    push("p1_en_blank0", 2'd0, 4'h0, 1'b0, 1'b0); check(obs1());
    repeat (9) tick1("p1_scan");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
